odd_clk_divider: RTL and testbench
==================================

# odd_clk_divider

Divides the single input clock by an odd integer DIV_PARAM and produces an output clock with exactly 50 % duty cycle, i.e. high for DIV_PARAM/2 input periods (a half-integer). It sits in the clock-generation area alongside the even, half-integer and fractional dividers. Its output feeds downstream logic or clock-tree consumers that need a symmetric low-frequency clock.

## Interface
- DIV_PARAM, default 5: odd division ratio. Legal values are odd integers ≥ 3. Any other value is an elaboration-time error.
- clk  input  1  input clock; both edges are used internally.
- rstn  input  1  synchronous, active-high reset (asserted = 1); the port keeps the codebase name `rstn`.
- clk_div  output  1  divided clock: period DIV_PARAM·Tclk, 50 % duty cycle.

## Operation
- Constants:
  - N = DIV_PARAM.
  - HALF = (N-1)/2.
  - CNT_W = $clog2(N).
- Rising-edge counter `cnt` (CNT_W bits) counts 0..N-1 and wraps.
  - At each posedge: cnt_next = (cnt == N-1) ? 0 : cnt+1.
- Rising-edge register `clk_p`: clk_p <= (cnt_next < HALF).
  - It is high for HALF input cycles out of every N, starting at the edge where cnt becomes 0.
- Falling-edge register `clk_n`: clk_n <= clk_p at each negedge.
  - It is `clk_p` delayed by half an input period.
- Output: clk_div = clk_p | clk_n, a combinational OR of two flop outputs.
  - High time is (HALF + 0.5)·Tclk = N/2·Tclk.
  - Low time is N/2·Tclk.
- Reset, while rstn = 1:
  - At posedge: cnt <= N-1 and clk_p <= 0.
  - At negedge: clk_n <= 0.
  - clk_div = 0 once both edges have been seen in reset.
- Counter reset value N-1 is chosen so that the first non-reset posedge yields cnt = 0 and clk_p = 1.

## Timing
- Latency: clk_div rises on the first posedge at which rstn is sampled 0.
- Rise and fall of clk_div:
  - Rising edges always coincide with clk posedges.
  - Falling edges always coincide with clk negedges.
- N = 5, Tclk = 10 ns, reset released before the posedge at t0:
  - clk_div rises at t0 and falls at t0+25 ns.
  - It rises again at t0+50 ns.
- N = 3: high 15 ns, low 15 ns.
- Reset asserted mid-operation:
  - clk_p clears at the next posedge; clk_n clears at the following negedge.
  - One truncated high pulse is permitted; no spurious pulse may start during reset.
- Reset released: no runt pulse. The first cycle is a full N/2 high phase.
- Glitches: the OR inputs change on opposite clock edges and never simultaneously, so clk_div has no glitches from skew between the inputs.

## Structure
- No shared package is required. N, HALF and CNT_W are localparams.
- The divider-family ratio check (odd ≥ 3) belongs in the shared `clk_div_pkg` if that package exists.
- Sub-module: `mod_n_counter` (parameter N, sync active-high reset to N-1, outputs cnt_next). It is reusable by the even divider.
- Top-level content is the counter instance, the two phase flops and the OR.

## Test plan
- N = 5, 100 MHz clk, reset held 200 ns then released:
  - clk_div = 0 during reset.
  - First rise at the first posedge after release; high 25 ns, low 25 ns.
  - Period 50 ns, checked over 20 periods.
- N = 3: high 15 ns, low 15 ns, period 30 ns. Rises are aligned to clk posedges and falls to clk negedges.
- N = 7 and N = 15: measured high time equals low time (35 ns and 75 ns), with no glitches (no edges narrower than Tclk/2).
- Reset pulsed for 3 cycles mid-high-phase:
  - clk_div is 0 by the negedge following the first reset posedge.
  - After release, the first rise is at the first non-reset posedge.
- Reset asserted at time 0 with X-initialised flops: clk_div resolves to 0 after one full clk period in reset.
- DIV_PARAM = 4 or 1: elaboration fails with an error message.

Source files
------------

// File: rtl/odd_clk_divider_pkg.sv
// rtl/odd_clk_divider_pkg.sv - shared constants and ratio checks for the odd clock divider
package odd_clk_divider_pkg;

  localparam int MIN_ODD_DIV = 3;

  // Divider-family legality rule: ratio must be odd and at least MIN_ODD_DIV.
  function automatic bit is_legal_odd_div(input int div);
    return (div >= MIN_ODD_DIV) && ((div % 2) == 1);
  endfunction

  function automatic int half_of(input int div);
    return (div - 1) / 2;
  endfunction

endpackage

// File: rtl/odd_clk_divider_counter.sv
// rtl/odd_clk_divider_counter.sv - mod-N rising-edge counter exposing its next value
module mod_n_counter #(
  parameter int N = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [$clog2(N)-1:0] cnt_next
);

  localparam int               CNT_W   = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end
  end

  // Reset to N-1 so the first free-running edge lands on zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_MAX;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_next = cnt_d;

endmodule

// File: rtl/odd_clk_divider.sv
// rtl/odd_clk_divider.sv - odd-ratio clock divider with exact 50% duty cycle
module odd_clk_divider
  import odd_clk_divider_pkg::*;
#(
  parameter int DIV_PARAM = 5
) (
  input  logic clk,
  input  logic rstn,
  output logic clk_div
);

  localparam int N     = DIV_PARAM;
  localparam int HALF  = half_of(N);
  localparam int CNT_W = $clog2(N);

  if (!is_legal_odd_div(DIV_PARAM)) begin : g_bad_div
    $error("odd_clk_divider: DIV_PARAM=%0d must be an odd integer >= 3", DIV_PARAM);
  end

  logic [CNT_W-1:0] cnt_next;
  logic             clk_p_q;
  logic             clk_p_d;
  logic             clk_n_q;
  logic             clk_n_d;

  mod_n_counter #(
    .N(N)
  ) u_counter (
    .clk     (clk),
    .rst     (rstn),
    .cnt_next(cnt_next)
  );

  always_comb begin
    clk_p_d = (cnt_next < CNT_W'(HALF));
    clk_n_d = clk_p_q;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      clk_p_q <= 1'b0;
    end else begin
      clk_p_q <= clk_p_d;
    end
  end

  // Half-period delayed copy stretches the high phase by Tclk/2.
  always_ff @(negedge clk) begin
    if (rstn) begin
      clk_n_q <= 1'b0;
    end else begin
      clk_n_q <= clk_n_d;
    end
  end

  assign clk_div = clk_p_q | clk_n_q;

endmodule

// File: tb/tb_odd_clk_divider.sv
// tb/tb_odd_clk_divider.sv - scoreboard bench for odd_clk_divider at ratios 5, 3, 7 and 15
`timescale 1ns/1ps
module tb_odd_clk_divider;

  localparam int NUM = 4;

  function automatic int n_of(input int i);
    case (i)
      0:       return 5;
      1:       return 3;
      2:       return 7;
      default: return 15;
    endcase
  endfunction

  typedef struct {
    time t;
    bit  v;
  } edge_t;

  logic           clk  = 1'b0;
  logic           rstn = 1'b1;
  logic [NUM-1:0] clk_div_w;
  edge_t          exp_q [NUM][$];
  int             total = 0;
  int             bad = 0;
  bit             mon_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NUM; g++) begin : g_dut
    odd_clk_divider #(
      .DIV_PARAM(n_of(g))
    ) u_dut (
      .clk    (clk),
      .rstn   (rstn),
      .clk_div(clk_div_w[g])
    );

    always @(clk_div_w[g]) begin : mon
      edge_t e;
      if (mon_en) begin
        total++;
        if (exp_q[g].size() == 0) begin
          bad++;
          $display("FAIL edge_unexpected n=%0d: got %0b at %0t, required no edge", n_of(g), clk_div_w[g], $time);
        end else begin
          e = exp_q[g].pop_front();
          if (e.t != $time || e.v != clk_div_w[g]) begin
            bad++;
            $display("FAIL edge n=%0d: got %0b at %0t, required %0b at %0t", n_of(g), clk_div_w[g], $time, e.v, e.t);
          end
        end
      end
    end
  end

  function automatic edge_t mk(input time t, input bit v);
    edge_t e;
    e.t = t;
    e.v = v;
    return e;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Ideal waveform from release posedge t0 until the reset-sampling posedge pa:
  // high for N*Tclk/2 starting at every t0 + k*N*Tclk; a pulse in flight at pa
  // survives half an input period past pa and then drops.
  task automatic push_segment(input time t0, input time pa);
    for (int i = 0; i < NUM; i++) begin
      time per;
      time hp;
      time d;
      per = time'(n_of(i)) * 10;
      hp  = time'(n_of(i)) * 5;
      for (time rt = t0; rt < pa; rt += per) begin
        exp_q[i].push_back(mk(rt, 1'b1));
        if (rt + hp < pa) exp_q[i].push_back(mk(rt + hp, 1'b0));
      end
      d = (pa - t0) % per;
      if (d != 0 && d < hp) exp_q[i].push_back(mk(pa + 5, 1'b0));
    end
  endtask

  task automatic check_all_low(input string name);
    for (int i = 0; i < NUM; i++) begin
      total++;
      if (clk_div_w[i] !== 1'b0) begin
        bad++;
        $display("FAIL %s n=%0d: got %b at %0t, required 0", name, n_of(i), clk_div_w[i], $time);
      end
    end
  endtask

  initial begin
    time tn;
    time t0;
    time pa;
    int  r;
    int  h;

    rstn = 1'b1;
    step();
    check_all_low("reset_state");
    mon_en = 1'b1;
    repeat (18) step();

    for (int seg = 0; seg < 14; seg++) begin
      r  = (seg == 0) ? 322 : int'($urandom_range(60, 1));
      h  = (seg == 0) ? 3 : int'($urandom_range(5, 1));
      tn = $time - 1;
      t0 = tn + 5;
      pa = t0 + time'(r) * 10;
      push_segment(t0, pa);
      rstn = 1'b0;
      repeat (r) step();
      rstn = 1'b1;
      step();
      check_all_low("reset_clear");
      repeat (h - 1) step();
    end

    repeat (4) step();
    for (int i = 0; i < NUM; i++) begin
      total++;
      if (exp_q[i].size() != 0) begin
        bad++;
        $display("FAIL missing_edges n=%0d: got %0d pending, required 0", n_of(i), exp_q[i].size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
